// File: rtl/uart_send_arbiter_pkg.sv
// Shared UART definitions: arbiter state encoding and the default frame width.
// Imported by the arbiter, its round-robin picker and the bus interface.
package uart_send_arbiter_pkg;

  localparam int UART_DATA_W = 40;
  localparam int GRANT_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_send_arbiter_if.sv
// Requester/transmitter bus of the UART send arbiter.
// The master side drives requests and send_done; the slave side is the arbiter.
interface uart_send_arbiter_if
  import uart_send_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      send_done;
  logic                      send;
  logic [DATA_W-1:0]         data;
  logic [GRANT_W-1:0]        grant_id;
  logic                      busy;
  logic                      err_timeout;

  modport master (
    output req, req_data, send_done,
    input  ack, send, data, grant_id, busy, err_timeout
  );

  modport slave (
    input  req, req_data, send_done,
    output ack, send, data, grant_id, busy, err_timeout
  );

endinterface

// File: rtl/uart_send_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester found scanning upward
// from ptr+1, wrapping at NUM_REQ.
module rr_pick
  import uart_send_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [GRANT_W-1:0] winner,
  output logic               valid
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  int unsigned idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!valid && req[idx[IDX_W-1:0]]) begin
        winner = GRANT_W'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_send_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters,
// with a per-frame transmit timeout and a guaranteed idle gap between frames.
module uart_send_arbiter
  import uart_send_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W,
  parameter int TIMEOUT = 1048575
) (
  input logic clk,
  input logic rst,
  uart_send_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e         state;
  arb_state_e         state_nxt;
  logic [GRANT_W-1:0] ptr_q;
  logic [GRANT_W-1:0] grant_q;
  logic [GRANT_W-1:0] pick_id;
  logic               pick_valid;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  frame_sel;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               err_q;
  logic               tmo_hit;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  assign tmo_hit = (tmo_cnt == TMO_LAST) && !bus.send_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: state_nxt = pick_valid ? ST_LOAD : ST_IDLE;
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: state_nxt = (bus.send_done || tmo_hit) ? ST_GAP : ST_SEND;
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GRANT_W'(i)) frame_sel = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // The winner is fixed on leaving IDLE so ack and grant_id are stable in LOAD;
  // the frame is captured at the end of LOAD, while ack tells the requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= GRANT_W'(NUM_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) grant_q <= pick_id;
        end
        ST_LOAD: begin
          data_q  <= frame_sel;
          ptr_q   <= grant_q;
          tmo_cnt <= '0;
        end
        ST_SEND: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_hit) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.ack  = '0;
    bus.send = 1'b0;
    bus.busy = 1'b1;
    case (state)
      ST_IDLE: bus.busy = 1'b0;
      ST_LOAD: bus.ack  = NUM_REQ'(1) << grant_q;
      ST_SEND: bus.send = 1'b1;
      ST_GAP:  ;
      default: bus.busy = 1'b0;
    endcase
  end

  assign bus.data        = data_q;
  assign bus.grant_id    = grant_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_send_arbiter.sv
// Directed bench for uart_send_arbiter: single grant, full round-robin,
// sole requester, frame stability, timeout and mid-frame reset.
module tb_uart_send_arbiter;
  import uart_send_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   lat;
  int   cnt;
  logic [39:0] frames [4];

  uart_send_arbiter_if #(.NUM_REQ(4), .DATA_W(40)) bus ();

  uart_send_arbiter #(.NUM_REQ(4), .DATA_W(40), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    bus.req = r;
  endtask

  task automatic waitAck(output int cycles);
    cycles = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      cycles++;
      if (bus.ack != 0) break;
    end
    checkOutput("ack_seen", 64'(bus.ack != 0), 64'd1);
  endtask

  // Serves one frame; returns one cycle into GAP with send_done low again.
  task automatic serveFrame(input int id, input logic [39:0] frame, input int doneDelay,
                            output int ackLat);
    waitAck(ackLat);
    checkOutput("ack_onehot", 64'(bus.ack), 64'(1) << id);
    checkOutput("grant_id", 64'(bus.grant_id), 64'(id));
    tick();
    checkOutput("ack_pulse", 64'(bus.ack), 64'd0);
    checkOutput("send_rise", 64'(bus.send), 64'd1);
    checkOutput("data", 64'(bus.data), 64'(frame));
    repeat (doneDelay) tick();
    checkOutput("send_hold", 64'(bus.send), 64'd1);
    bus.send_done = 1'b1;
    tick();
    bus.send_done = 1'b0;
    checkOutput("send_fall", 64'(bus.send), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    frames[0] = 40'h00000FCF9E7;
    frames[1] = 40'h123456789A;
    frames[2] = 40'hA55A5AA55A;
    frames[3] = 40'hFF0000FF01;
    bus.req       = '0;
    bus.send_done = 1'b0;
    for (int i = 0; i < 4; i++) bus.req_data[i*40 +: 40] = frames[i];

    #1;
    checkOutput("rst_send", 64'(bus.send), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_ack", 64'(bus.ack), 64'd0);
    checkOutput("rst_data", 64'(bus.data), 64'd0);
    checkOutput("rst_grant", 64'(bus.grant_id), 64'd0);
    checkOutput("rst_err", 64'(bus.err_timeout), 64'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    $display("[TB] single requester 0");
    applyStimulus(4'b0001);
    serveFrame(0, frames[0], 2, lat);
    checkOutput("req_to_ack", 64'(lat), 64'd1);
    applyStimulus(4'b0000);
    checkOutput("gap_busy", 64'(bus.busy), 64'd1);
    tick();
    checkOutput("idle_busy", 64'(bus.busy), 64'd0);

    $display("[TB] stray send_done in IDLE");
    bus.send_done = 1'b1;
    tick();
    bus.send_done = 1'b0;
    checkOutput("stray_done_busy", 64'(bus.busy), 64'd0);
    checkOutput("stray_done_send", 64'(bus.send), 64'd0);

    $display("[TB] all requesters, order 0,1,2,3,0");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    applyStimulus(4'b1111);
    serveFrame(0, frames[0], 3, lat);
    serveFrame(1, frames[1], 3, lat);
    serveFrame(2, frames[2], 3, lat);
    serveFrame(3, frames[3], 3, lat);
    serveFrame(0, frames[0], 3, lat);

    $display("[TB] sole requester 2");
    applyStimulus(4'b0100);
    for (int r = 0; r < 3; r++) serveFrame(2, frames[2], 1, lat);
    applyStimulus(4'b0000);

    $display("[TB] frame stability during SEND");
    applyStimulus(4'b0010);
    waitAck(lat);
    checkOutput("stab_ack", 64'(bus.ack), 64'b0010);
    tick();
    checkOutput("stab_data0", 64'(bus.data), 64'(frames[1]));
    bus.req_data[79:40] = 40'hDEADBEEF00;
    applyStimulus(4'b0000);
    repeat (2) tick();
    checkOutput("stab_data1", 64'(bus.data), 64'(frames[1]));
    checkOutput("stab_send", 64'(bus.send), 64'd1);
    checkOutput("stab_noack", 64'(bus.ack), 64'd0);
    bus.send_done = 1'b1;
    tick();
    bus.send_done = 1'b0;
    checkOutput("stab_fall", 64'(bus.send), 64'd0);
    checkOutput("stab_data2", 64'(bus.data), 64'(frames[1]));
    repeat (2) tick();
    checkOutput("stab_idle", 64'(bus.busy), 64'd0);
    checkOutput("stab_noack2", 64'(bus.ack), 64'd0);
    bus.req_data[79:40] = frames[1];

    $display("[TB] transmit timeout");
    applyStimulus(4'b1000);
    waitAck(lat);
    checkOutput("tmo_grant", 64'(bus.grant_id), 64'd3);
    tick();
    checkOutput("tmo_err_before", 64'(bus.err_timeout), 64'd0);
    applyStimulus(4'b0000);
    cnt = 0;
    for (int n = 0; n < 40 && bus.send; n++) begin
      cnt++;
      tick();
    end
    checkOutput("tmo_len", 64'(cnt), 64'd16);
    checkOutput("tmo_err", 64'(bus.err_timeout), 64'd1);
    checkOutput("tmo_gap_busy", 64'(bus.busy), 64'd1);
    tick();
    checkOutput("tmo_err_sticky", 64'(bus.err_timeout), 64'd1);
    applyStimulus(4'b0001);
    serveFrame(0, frames[0], 2, lat);
    applyStimulus(4'b0000);
    checkOutput("tmo_err_kept", 64'(bus.err_timeout), 64'd1);

    $display("[TB] reset during SEND");
    tick();
    applyStimulus(4'b0100);
    waitAck(lat);
    checkOutput("mid_grant", 64'(bus.grant_id), 64'd2);
    tick();
    checkOutput("mid_send", 64'(bus.send), 64'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("mid_rst_send", 64'(bus.send), 64'd0);
    checkOutput("mid_rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("mid_rst_err", 64'(bus.err_timeout), 64'd0);
    checkOutput("mid_rst_data", 64'(bus.data), 64'd0);
    tick();
    rst = 1'b1;
    applyStimulus(4'b1111);
    serveFrame(0, frames[0], 1, lat);
    applyStimulus(4'b0000);
    repeat (2) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
